// File: rtl/avr_mem_pkg.sv
// avr_mem_pkg: shared definitions for the AVR data-bus memory router.
//   - channel index constants for the board's memory set
//   - read-source select type carried down the read pipeline
//   - default bank port and window base addresses
package avr_mem_pkg;

  localparam int unsigned CH_SRAM = 0;
  localparam int unsigned CH_TEXT = 1;
  localparam int unsigned CH_FONT = 2;
  localparam int unsigned CH_GFX  = 3;

  localparam logic [15:0] DEF_BANK_PORT   = 16'h0058;
  localparam logic [15:0] DEF_WINDOW_BASE = 16'hE000;

  // Wide enough for the largest supported channel count (16).
  localparam int unsigned SEL_CH_W = 4;

  typedef enum logic [1:0] {
    SRC_CH,
    SRC_BANK,
    SRC_UNMAPPED
  } src_kind_t;

  typedef struct packed {
    src_kind_t             kind;
    logic [SEL_CH_W-1:0]   ch;
  } src_sel_t;

endpackage

// File: rtl/avr_rdsel_pipe.sv
// avr_rdsel_pipe: delay line carrying {read source, sampled bank} so the
// read-data mux lines up with the synchronous memory read latency.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   src_in        source decoded in the address cycle
//   bank_in       bank register value in the address cycle
//   src_out       source after RD_LAT cycles
//   bank_out      bank value after RD_LAT cycles
module avr_rdsel_pipe
  import avr_mem_pkg::*;
#(
  parameter int unsigned BANK_W = 6,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  src_sel_t          src_in,
  input  logic [BANK_W-1:0] bank_in,
  output src_sel_t          src_out,
  output logic [BANK_W-1:0] bank_out
);

  typedef struct packed {
    src_sel_t          src;
    logic [BANK_W-1:0] bank;
  } stage_t;

  localparam stage_t RST_STAGE = '{
    src:  '{kind: SRC_CH, ch: SEL_CH_W'(CH_SRAM)},
    bank: '0
  };

  stage_t stg [RD_LAT];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) stg[i] <= RST_STAGE;
    end else begin
      stg[0] <= '{src: src_in, bank: bank_in};
      for (int unsigned i = 1; i < RD_LAT; i++) stg[i] <= stg[i-1];
    end
  end

  assign src_out  = stg[RD_LAT-1].src;
  assign bank_out = stg[RD_LAT-1].bank;

endmodule

// File: rtl/avr_memrouter.sv
// avr_memrouter: routes the AVR core data port onto a set of memory channels.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   address       CPU data address
//   data_o        CPU write data
//   wren          CPU write enable
//   data_i        read data back to the CPU (RD_LAT cycles after address)
//   ch_address    address shared by all channels (window-remapped)
//   ch_data       write data shared by all channels
//   ch_wren       one-hot channel write strobes
//   ch_q          packed channel read data, channel i at [i*DATA_W +: DATA_W]
//   bank          bank register {page, channel}
//   wp_fault      sticky: a write to a protected channel was dropped
module avr_memrouter
  import avr_mem_pkg::*;
#(
  parameter int unsigned            ADDR_W      = 16,
  parameter int unsigned            DATA_W      = 8,
  parameter int unsigned            CHANNELS    = 4,
  parameter int unsigned            BANK_W      = 6,
  parameter logic [ADDR_W-1:0]      WINDOW_BASE = DEF_WINDOW_BASE,
  parameter int unsigned            WINDOW_W    = 12,
  parameter logic [ADDR_W-1:0]      BANK_PORT   = DEF_BANK_PORT,
  parameter int unsigned            RD_LAT      = 1,
  parameter logic [CHANNELS-1:0]    WP_MASK     = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_W-1:0]            data_o,
  input  logic                         wren,
  output logic [DATA_W-1:0]            data_i,
  output logic [ADDR_W-1:0]            ch_address,
  output logic [DATA_W-1:0]            ch_data,
  output logic [CHANNELS-1:0]          ch_wren,
  input  logic [CHANNELS*DATA_W-1:0]   ch_q,
  output logic [BANK_W-1:0]            bank,
  output logic                         wp_fault
);

  localparam int unsigned CH_W   = $clog2(CHANNELS);
  localparam int unsigned PAGE_W = BANK_W - CH_W;
  localparam int unsigned MAP_W  = PAGE_W + WINDOW_W;
  localparam int unsigned WIDE_W = (MAP_W > ADDR_W) ? MAP_W : ADDR_W;

  logic [CH_W-1:0]   win_ch;
  logic [PAGE_W-1:0] page;
  logic [WIDE_W-1:0] win_addr;
  logic              in_window;
  logic              wp_hit;
  src_sel_t          src;
  src_sel_t          rd_src;
  logic [BANK_W-1:0] rd_bank;

  assign win_ch  = bank[CH_W-1:0];
  assign page    = bank[BANK_W-1:CH_W];
  assign ch_data = data_o;

  // Address decode; bank port has priority over the window.
  always_comb begin
    win_addr   = WIDE_W'({page, address[WINDOW_W-1:0]});
    in_window  = (address[ADDR_W-1:WINDOW_W] == WINDOW_BASE[ADDR_W-1:WINDOW_W]);
    src        = '{kind: SRC_CH, ch: SEL_CH_W'(CH_SRAM)};
    ch_address = address;
    if (address == BANK_PORT) begin
      src.kind = SRC_BANK;
    end else if (in_window) begin
      ch_address = win_addr[ADDR_W-1:0];
      if (32'(win_ch) < CHANNELS) src.ch = SEL_CH_W'(win_ch);
      else                        src.kind = SRC_UNMAPPED;
    end
  end

  always_comb begin
    ch_wren = '0;
    wp_hit  = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (wren && src.kind == SRC_CH && src.ch == SEL_CH_W'(i)) begin
        if (WP_MASK[i]) wp_hit     = 1'b1;
        else            ch_wren[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bank     <= '0;
      wp_fault <= 1'b0;
    end else begin
      if (wren && address == BANK_PORT) bank <= data_o[BANK_W-1:0];
      if (wp_hit) wp_fault <= 1'b1;
    end
  end

  // The bank value enters the pipe alongside the source so a bank-port read
  // returns the value from its own address cycle, not a later update.
  avr_rdsel_pipe #(
    .BANK_W (BANK_W),
    .RD_LAT (RD_LAT)
  ) u_rdsel (
    .clock    (clock),
    .reset    (reset),
    .src_in   (src),
    .bank_in  (bank),
    .src_out  (rd_src),
    .bank_out (rd_bank)
  );

  always_comb begin
    data_i = '0;
    case (rd_src.kind)
      SRC_BANK: data_i = DATA_W'(rd_bank);
      SRC_CH: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (rd_src.ch == SEL_CH_W'(i)) data_i = ch_q[i*DATA_W +: DATA_W];
        end
      end
      default: data_i = '0;
    endcase
  end

endmodule

// File: tb/tb_avr_memrouter.sv
module tb_avr_memrouter;

  logic        clock;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_o;
  logic        wren;
  logic [7:0]  qbase;
  logic        hold_q;

  // Instance A: 4 channels, RD_LAT=2, channel 2 protected.
  logic [7:0]  data_iA, ch_dataA;
  logic [15:0] ch_addressA;
  logic [3:0]  ch_wrenA;
  logic [31:0] ch_qA;
  logic [5:0]  bankA;
  logic        wpA;

  // Instance B: 3 channels, RD_LAT=1, no protection.
  logic [7:0]  data_iB, ch_dataB;
  logic [15:0] ch_addressB;
  logic [2:0]  ch_wrenB;
  logic [23:0] ch_qB;
  logic [5:0]  bankB;
  logic        wpB;

  int nerr = 0;
  int nchk = 0;
  bit armed = 0;

  always_comb begin
    for (int i = 0; i < 4; i++) ch_qA[i*8 +: 8] = qbase ^ 8'(i * 17);
    for (int i = 0; i < 3; i++) ch_qB[i*8 +: 8] = qbase ^ 8'(i * 17);
  end

  avr_memrouter #(.RD_LAT(2), .WP_MASK(4'b0100)) dut_a (
    .clock(clock), .reset(reset), .address(address), .data_o(data_o),
    .wren(wren), .data_i(data_iA), .ch_address(ch_addressA),
    .ch_data(ch_dataA), .ch_wren(ch_wrenA), .ch_q(ch_qA),
    .bank(bankA), .wp_fault(wpA));

  avr_memrouter #(.CHANNELS(3), .RD_LAT(1), .WP_MASK(3'b000)) dut_b (
    .clock(clock), .reset(reset), .address(address), .data_o(data_o),
    .wren(wren), .data_i(data_iB), .ch_address(ch_addressB),
    .ch_data(ch_dataB), .ch_wren(ch_wrenB), .ch_q(ch_qB),
    .bank(bankB), .wp_fault(wpB));

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // sel: -2 bank port, -1 unmapped, >=0 channel number
  typedef struct { int sel; int bv; } rec_t;
  rec_t qA[$];
  rec_t qB[$];
  int   mbA, mbB;
  int   mfA, mfB;

  function automatic void mdec(input int chans, input int chw, input int a,
                               input int bv, output int sel, output int caddr);
    int ch, pg;
    if (a == 'h0058) begin
      sel = -2; caddr = a;
    end else if (a >= 'hE000 && a <= 'hEFFF) begin
      ch    = bv % (1 << chw);
      pg    = bv / (1 << chw);
      caddr = (pg * 4096 + a % 4096) % 65536;
      sel   = (ch < chans) ? ch : -1;
    end else begin
      sel = 0; caddr = a;
    end
  endfunction

  function automatic int exp_data(input rec_t r, input int qb);
    if (r.sel == -2) return r.bv;
    if (r.sel == -1) return 0;
    return (qb ^ (r.sel * 17)) & 255;
  endfunction

  function automatic int exp_wren(input int sel, input int w, input int wp);
    if (w != 0 && sel >= 0 && ((wp >> sel) & 1) == 0) return 1 << sel;
    return 0;
  endfunction

  always @(posedge clock) begin
    int sel, ca;
    if (reset) begin
      mbA = 0; mbB = 0; mfA = 0; mfB = 0;
      qA.delete(); qB.delete();
      repeat (2) qA.push_back('{0, 0});
      qB.push_back('{0, 0});
      armed = 1;
    end else begin
      mdec(4, 2, int'(address), mbA, sel, ca);
      qA.push_back('{sel, mbA}); void'(qA.pop_front());
      if (wren && sel >= 0 && ((4 >> sel) & 1) == 1) mfA = 1;
      mdec(3, 2, int'(address), mbB, sel, ca);
      qB.push_back('{sel, mbB}); void'(qB.pop_front());
      if (wren && address == 16'h0058) begin
        mbA = int'(data_o) % 64;
        mbB = int'(data_o) % 64;
      end
    end
  end

  always @(negedge clock) begin
    int sel, ca;
    if (armed) begin
      mdec(4, 2, int'(address), mbA, sel, ca);
      chk("A.data_i", int'(data_iA), exp_data(qA[0], int'(qbase)));
      chk("A.bank", int'(bankA), mbA);
      chk("A.wp_fault", int'(wpA), mfA);
      chk("A.ch_wren", int'(ch_wrenA), exp_wren(sel, int'(wren), 4));
      if (sel != -2) chk("A.ch_address", int'(ch_addressA), ca);
      chk("A.ch_data", int'(ch_dataA), int'(data_o));
      mdec(3, 2, int'(address), mbB, sel, ca);
      chk("B.data_i", int'(data_iB), exp_data(qB[0], int'(qbase)));
      chk("B.bank", int'(bankB), mbB);
      chk("B.wp_fault", int'(wpB), mfB);
      chk("B.ch_wren", int'(ch_wrenB), exp_wren(sel, int'(wren), 0));
      if (sel != -2) chk("B.ch_address", int'(ch_addressB), ca);
      chk("B.ch_data", int'(ch_dataB), int'(data_o));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic w);
    @(posedge clock);
    #1;
    address = a;
    data_o  = d;
    wren    = w;
    if (!hold_q) qbase = 8'($urandom);
  endtask

  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w);
    cyc(a, d, w);
    @(negedge clock);
  endtask

  initial begin
    reset = 1; address = '0; data_o = '0; wren = 0;
    qbase = 8'h5A; hold_q = 1;

    // Reset for two cycles
    step(16'h0000, 8'h00, 0);
    step(16'h0000, 8'h00, 0);
    chk("rst.bankA", int'(bankA), 0);
    chk("rst.wpA", int'(wpA), 0);
    chk("rst.data_iA", int'(data_iA), 'h5A);
    chk("rst.data_iB", int'(data_iB), 'h5A);
    reset = 0;

    // Plain SRAM write and read-back
    qbase = 8'hA5;
    step(16'h0100, 8'hA5, 1);
    chk("sram.ch_wrenA", int'(ch_wrenA), 'b0001);
    chk("sram.ch_addressA", int'(ch_addressA), 'h0100);
    step(16'h0100, 8'h00, 0);
    step(16'h0200, 8'h00, 0);
    chk("sram.data_iB", int'(data_iB), 'hA5);
    step(16'h0200, 8'h00, 0);
    chk("sram.data_iA", int'(data_iA), 'hA5);

    // Window remap: bank = page 0101, channel 1
    step(16'h0058, 8'h15, 1);
    step(16'hE123, 8'h42, 1);
    chk("remap.ch_wrenA", int'(ch_wrenA), 'b0010);
    chk("remap.ch_addressA", int'(ch_addressA), 'h5123);
    chk("remap.ch_wrenB", int'(ch_wrenB), 'b010);

    // Bank-change race on the RD_LAT=2 instance
    qbase = 8'h3C;
    step(16'hE000, 8'h00, 0);
    step(16'h0058, 8'h02, 1);
    step(16'hE000, 8'h00, 0);
    chk("race.cyc2.data_iA", int'(data_iA), 'h2D);
    step(16'h0200, 8'h00, 0);
    step(16'h0200, 8'h00, 0);
    chk("race.cyc4.data_iA", int'(data_iA), 'h1E);

    // Write protect (channel 2 on A only)
    hold_q = 0;
    step(16'hE010, 8'h77, 1);
    chk("wp.ch_wrenA", int'(ch_wrenA), 0);
    chk("wp.ch_wrenB", int'(ch_wrenB), 'b100);
    step(16'h0300, 8'h00, 0);
    chk("wp.wpA", int'(wpA), 1);
    chk("wp.wpB", int'(wpB), 0);

    // Unmapped channel 3 on B
    step(16'h0058, 8'h03, 1);
    step(16'hE040, 8'h00, 0);
    step(16'hE040, 8'h55, 1);
    chk("unmap.data_iB", int'(data_iB), 0);
    chk("unmap.ch_wrenB", int'(ch_wrenB), 0);
    chk("unmap.ch_wrenA", int'(ch_wrenA), 'b1000);

    // Bank port read-back
    step(16'h0058, 8'h00, 0);
    step(16'h0000, 8'h00, 0);
    chk("bankrd.data_iB", int'(data_iB), 3);
    step(16'h0000, 8'h00, 0);
    chk("bankrd.data_iA", int'(data_iA), 3);

    // Mixed traffic, checked against the model every cycle
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 3))
        0:       a = 16'h0058;
        1, 2:    a = 16'hE000 | 16'($urandom_range(0, 4095));
        default: a = 16'($urandom);
      endcase
      step(a, 8'($urandom), 1'($urandom));
    end

    // Reset mid-operation clears the sticky fault and flushes read selects
    chk("pre_rst.wpA", int'(wpA), 1);
    step(16'hE000, 8'h00, 0);
    reset = 1;
    hold_q = 1; qbase = 8'h81;
    step(16'hE000, 8'h00, 0);
    step(16'hE000, 8'h00, 0);
    chk("midrst.wpA", int'(wpA), 0);
    chk("midrst.bankA", int'(bankA), 0);
    chk("midrst.data_iA", int'(data_iA), 'h81);
    reset = 0;
    hold_q = 0;
    repeat (6) step(16'hE000 | 16'($urandom_range(0, 4095)), 8'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
